// File: rtl/pipe_reg_s.sv
// Single-stage pipeline register with reset/flush to a caller-supplied default
// value and a hold (stall) input; data_o comes straight from the storage flop.
module pipe_reg_s #(
  parameter int dw = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_default,
  input  logic          hold_en,
  input  logic [dw-1:0] default_data_i,
  input  logic [dw-1:0] data_i,
  output logic [dw-1:0] data_o
);

  logic [dw-1:0] data_reg;

  // rst_n is active-high here; reset and flush both reload the default, and
  // either one overrides hold.
  always_ff @(posedge clk) begin
    if (rst_n || set_default) begin
      data_reg <= default_data_i;
    end else if (!hold_en) begin
      data_reg <= data_i;
    end
  end

  assign data_o = data_reg;

endmodule

// File: tb/tb_pipe_reg_s.sv
// Directed and randomized checks of pipe_reg_s at dw=32 and dw=1 against an
// expected-value model kept in the bench.
module tb_pipe_reg_s;

  logic        clk = 1'b0;
  logic        rst_n, set_default, hold_en;
  logic [31:0] dflt32, din32, dout32;
  logic [0:0]  dflt1, din1, dout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_reg_s #(.dw(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .set_default(set_default), .hold_en(hold_en),
    .default_data_i(dflt32), .data_i(din32), .data_o(dout32)
  );

  pipe_reg_s #(.dw(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .set_default(set_default), .hold_en(hold_en),
    .default_data_i(dflt1), .data_i(din1), .data_o(dout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m32;
  logic [0:0]  m1;
  logic        r_rst, r_flush, r_hold;

  initial begin
    rst_n = 1'b1; set_default = 1'b0; hold_en = 1'b0;
    dflt32 = 32'h0000_0013; din32 = 32'hDEAD_BEEF;
    dflt1 = 1'b0; din1 = 1'b1;

    // Reset for two edges, then release.
    tick(); check("rst_edge1", dout32, 32'h0000_0013);
    check("rst_edge1_w1", {31'd0, dout1}, 32'd0);
    tick(); check("rst_edge2", dout32, 32'h0000_0013);
    rst_n = 1'b0;
    tick(); check("rst_release", dout32, 32'hDEAD_BEEF);
    $display("reset sequence: data_o=0x%08h", dout32);

    // Pass-through, both widths.
    din32 = 32'h1; din1 = 1'b1; tick(); check("pass1", dout32, 32'h1); check("pass1_w1", {31'd0, dout1}, 32'd1);
    din32 = 32'h2; din1 = 1'b0; tick(); check("pass2", dout32, 32'h2); check("pass2_w1", {31'd0, dout1}, 32'd0);
    dflt32 = 32'h0000_0099;
    din32 = 32'h3; din1 = 1'b1; tick(); check("pass3", dout32, 32'h3); check("pass3_w1", {31'd0, dout1}, 32'd1);
    $display("pass-through: data_o=0x%08h", dout32);

    // Hold for three edges with changing data_i.
    din32 = 32'h10; tick(); check("hold_load", dout32, 32'h10);
    hold_en = 1'b1;
    din32 = 32'h20; tick(); check("hold1", dout32, 32'h10);
    din32 = 32'h30; tick(); check("hold2", dout32, 32'h10);
    din32 = 32'h40; tick(); check("hold3", dout32, 32'h10);
    hold_en = 1'b0; din32 = 32'h50; tick(); check("hold_release", dout32, 32'h50);
    $display("hold: data_o=0x%08h", dout32);

    // Flush with and without hold.
    din32 = 32'hAAAA_5555; tick(); check("flush_pre", dout32, 32'hAAAA_5555);
    dflt32 = 32'h0000_0013; set_default = 1'b1; hold_en = 1'b1;
    tick(); check("flush_hold", dout32, 32'h0000_0013);
    check("flush_hold_w1", {31'd0, dout1}, 32'd0);
    set_default = 1'b0; hold_en = 1'b0;
    tick(); check("flush_pre2", dout32, 32'hAAAA_5555);
    set_default = 1'b1;
    tick(); check("flush_nohold", dout32, 32'h0000_0013);
    set_default = 1'b0;
    $display("flush: data_o=0x%08h", dout32);

    // Reset beats hold; a reset pulse between edges has no effect.
    din32 = 32'h77; tick(); check("rstpri_pre", dout32, 32'h77);
    rst_n = 1'b1; hold_en = 1'b1; dflt32 = 32'h0;
    tick(); check("rst_over_hold", dout32, 32'h0);
    rst_n = 1'b0; hold_en = 1'b0;
    tick(); check("rstpri_reload", dout32, 32'h77);
    hold_en = 1'b1;
    #2 rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("rst_glitch_mid", dout32, 32'h77);
    tick(); check("rst_glitch_edge", dout32, 32'h77);
    hold_en = 1'b0;
    $display("reset priority: data_o=0x%08h", dout32);

    // Randomized run against a rule-table model.
    m32 = dout32; m1 = dout1;
    for (int i = 0; i < 300; i++) begin
      r_rst   = ($urandom_range(0, 15) == 0);
      r_flush = ($urandom_range(0, 7) == 0);
      r_hold  = ($urandom_range(0, 3) == 0);
      rst_n = r_rst; set_default = r_flush; hold_en = r_hold;
      dflt32 = $urandom; din32 = $urandom;
      dflt1 = 1'($urandom); din1 = 1'($urandom);
      // Highest-priority active request decides what the edge stores.
      case (1'b1)
        r_rst, r_flush: begin m32 = dflt32; m1 = dflt1; end
        r_hold:         begin end
        default:        begin m32 = din32; m1 = din1; end
      endcase
      tick();
      check("rand32", dout32, m32);
      check("rand1", {31'd0, dout1}, {31'd0, m1});
      $display("rand %0d: rst=%0b flush=%0b hold=%0b data_o=0x%08h/%0b", i, r_rst, r_flush, r_hold, dout32, dout1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_s.md
Name: pipe_reg_s

Overview:
Generic single-stage pipeline register with synchronous reset, flush-to-default and hold (stall) control. Every field of the core's inter-stage latches (e.g. IF/ID instruction, instruction address, predict-jump flag) is built from one instance per field. On flush the stage is loaded with a caller-supplied default value (e.g. NOP encoding, zero, disable flag) instead of a hard-wired constant.

Parameters:
dw, 32, data width in bits of default_data_i, data_i and data_o; legal range 1..1024.

Ports:
clk  input  1  clock; all state updates on rising edge only
rst_n  input  1  synchronous reset, active-high; sampled on rising clk edge
set_default  input  1  flush request; load default_data_i on next edge
hold_en  input  1  stall request; retain current contents on next edge
default_data_i  input  dw  value loaded on reset or flush
data_i  input  dw  next-stage data from upstream
data_o  output  dw  registered output, driven directly from the storage flop

Behaviour:
- One dw-bit register; data_o is the register value, no combinational path from any input to data_o.
- Per rising clk edge, strict priority:
  1. rst_n == 1: reg <= default_data_i.
  2. else set_default == 1: reg <= default_data_i (flush beats hold).
  3. else hold_en == 1: reg <= reg.
  4. else: reg <= data_i.
- Latency: exactly 1 cycle from data_i/default_data_i sample to data_o.
- Reset value of data_o: the default_data_i value present at the reset edge. Before the first clk edge the output is undefined (X in simulation); no initial block.
- Reset is synchronous: asserting rst_n between edges does not change data_o until the next rising edge. Deasserting it lets the next edge perform normal priority evaluation.
- Reset mid-hold or mid-flush: reset wins; the result is the same as a flush.
- set_default and hold_en both high: flush wins; reg <= default_data_i.
- default_data_i is sampled only on reset/flush edges. Changes to it at other times have no effect on data_o.
- Hold persists for any number of consecutive cycles with no drift. On release, the first edge loads data_i.
- No X-propagation masking: an X on a selected input propagates to data_o. An X on a non-selected input must not.
- Width rule: all data paths are dw bits, no truncation or sign extension. dw = 1 must synthesize to a single flop.

Test Plan:
- Reset: dw=32, default_data_i=0x00000013, data_i=0xDEADBEEF, rst_n=1 for 2 edges -> data_o=0x00000013 after the first edge. Drop rst_n -> next edge data_o=0xDEADBEEF.
- Pass-through: controls low, data_i sequence 0x1,0x2,0x3 on consecutive edges -> data_o shows 0x1,0x2,0x3, each one cycle late.
- Hold: data_o=0x10, hold_en=1 for 3 edges while data_i=0x20,0x30,0x40 -> data_o stays 0x10. Release with data_i=0x50 -> next edge data_o=0x50.
- Flush vs hold: data_o=0xAAAA5555, set_default=1 and hold_en=1, default_data_i=0x00000013 -> next edge data_o=0x00000013. Same with hold_en=0 -> same result.
- Reset priority: rst_n=1, set_default=0, hold_en=1, default_data_i=0x0, data_o=0x77 -> next edge data_o=0x0. Pulse rst_n between edges only -> data_o unchanged.
- Width: dw=1, default_data_i=0, data_i toggling 1,0,1 -> data_o follows one cycle late. Flush -> 0.
